hazard_sequencer: RTL and testbench
===================================

# hazard_sequencer

Pipeline hazard controller for the 5-stage processor: detects load-use hazards between the decode stage and a load in execute, sequences stall and flush cycles, and drives the PC, IF/ID and ID/EX pipeline-register controls. Branch resolution in EX/DM and jumps decoded in ID both trigger a flush. It sits beside the decode control unit and gates the pipeline registers around it. Optional performance counters report stall cycles and flush events.

## Interface
- `LOAD_STALL_CYCLES`, default 1: total cycles `pc_write` is held low per load-use hazard; must be ≥1.
- `FLUSH_CYCLES`, default 1: total cycles of flush per taken branch, including the detection cycle; must be ≥1.
- `clk` in 1: single clock; every register updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `id_opcode` in 6: opcode of the instruction in ID.
- `id_rs` in 5: rs field of the instruction in ID.
- `id_rt` in 5: rt field of the instruction in ID.
- `ex_mem_read` in 1: the instruction in EX is a load.
- `ex_rt` in 5: destination register of the load in EX.
- `branch_out_ex_dm` in 1: taken branch resolved at the EX/DM boundary.
- `pc_write` out 1: PC load enable.
- `ifid_write` out 1: IF/ID register load enable.
- `ifid_flush` out 1: clear IF/ID to a NOP.
- `idex_bubble` out 1: force all ID/EX control bits to 0.
- `hz_state` out 2: current FSM state, for debug.
- `stall_count` out 32: count of stall cycles.
- `flush_count` out 32: count of flush events.

## Operation
- Opcodes: RType 000000, LW 000001, SW 000010, BEQ 000011, ADDI 000100, JUMP 000101.
- **Load-use condition** (`lu`):
  - requires `ex_mem_read` and `ex_rt != 0`;
  - and either `ex_rt == id_rs` for RType, LW, SW, BEQ or ADDI;
  - or `ex_rt == id_rt` for RType, SW or BEQ only.
  - JUMP and unknown opcodes never hazard.
- **FSM states**: RUN = 0, STALL = 1, FLUSH = 2. Control is Mealy: outputs depend on the current state and the current inputs.
- **Priority**: `branch_out_ex_dm` > load-use > jump.
- **RUN state**:
  - Branch taken: `ifid_flush=1`, `idex_bubble=1`, `pc_write=ifid_write=1`. Next state is FLUSH if `FLUSH_CYCLES>1` (remaining counter = `FLUSH_CYCLES-2`), else RUN.
  - Else `lu`: `pc_write=ifid_write=0`, `idex_bubble=1`. Next state is STALL if `LOAD_STALL_CYCLES>1` (remaining counter = `LOAD_STALL_CYCLES-2`), else RUN.
  - Else `id_opcode==JUMP`: `ifid_flush=1`, `pc_write=ifid_write=1`; stay RUN.
  - Else: `pc_write=ifid_write=1`, all other controls 0.
- **STALL state**:
  - Outputs are the same as the RUN `lu` case.
  - Counter at 0 → RUN; otherwise decrement.
  - Branch taken overrides: the RUN-branch outputs and transition apply, and the stall is abandoned.
- **FLUSH state**:
  - `ifid_flush=1`, `idex_bubble=1`, `pc_write=ifid_write=1`.
  - `lu` and jump are ignored.
  - Counter at 0 → RUN.
  - A new branch taken reloads the counter to `FLUSH_CYCLES-2`, or returns to RUN if `FLUSH_CYCLES==1`.
- **Counters**: `stall_count` +1 in every cycle with `pc_write==0`, excluding reset. `flush_count` +1 per branch-taken cycle or accepted jump. Both wrap from 0xFFFFFFFF to 0.

## Timing
- While `reset=1`: `pc_write=0`, `ifid_write=0`, `ifid_flush=1`, `idex_bubble=1`, `hz_state=0`. No counter increments.
- On the first edge with `reset=1`: state RUN, internal counter 0, `stall_count=flush_count=0`.
- Reset asserted mid-STALL or mid-FLUSH aborts the sequence immediately.
- Hazard response is zero latency: controls change in the same cycle the inputs are presented.
- State, down-counter and perf counters update at the next rising edge.
- The down-counter width is `$clog2` of the larger parameter, with a minimum of 1 bit.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: `stall_count` and `flush_count` are implemented as described.
- Undefined: both ports remain and are tied to 0; no counter flops are inferred.

## Structure
- Package `hazard_pkg` holds:
  - the opcode constants;
  - the state encoding (RUN/STALL/FLUSH as a 2-bit typedef);
  - the `uses_rt_src(opcode)` function.
- Sub-module `hazard_perf_counter`: a 32-bit wrapping counter with `inc` and synchronous `reset`. It is instantiated twice, only under `HAZARD_PERF_CNT_EN`.

## Test plan
- Release reset, no load in EX; RType in ID → `pc_write=ifid_write=1`, `ifid_flush=idex_bubble=0`, `hz_state=0`, counters 0.
- LW into r5 in EX, RType in ID with rs=5 → one cycle `pc_write=0`, `idex_bubble=1`, `stall_count=1`. Repeat with ADDI rt=5 → no stall. Repeat with `ex_rt=0` → no stall.
- `LOAD_STALL_CYCLES=3`, SW with rt=5 against LW r5 → `pc_write=0` for exactly 3 cycles, `hz_state` sequence 0,1,1,0, `stall_count=3`.
- `FLUSH_CYCLES=2`: `branch_out_ex_dm` pulsed in the same cycle as a load-use → flush wins, `pc_write=1`, `ifid_flush=idex_bubble=1` for 2 cycles, `flush_count=1`, `stall_count=0`.
- JUMP in ID in RUN → `ifid_flush=1` for one cycle, `idex_bubble=0`, `flush_count` +1. JUMP during FLUSH → not counted.
- Reset asserted in the 2nd cycle of a 3-cycle STALL → reset outputs that cycle, RUN after, counters 0. Preload `stall_count=0xFFFFFFFF` and stall once → count reads 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared opcodes, FSM state encoding and operand-usage decode for the hazard sequencer.
package hazard_pkg;

   localparam int unsigned OPC_W  = 6;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned PERF_W = 32;

   localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
   localparam logic [OPC_W-1:0] OPC_LW    = 6'b000001;
   localparam logic [OPC_W-1:0] OPC_SW    = 6'b000010;
   localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000011;
   localparam logic [OPC_W-1:0] OPC_ADDI  = 6'b000100;
   localparam logic [OPC_W-1:0] OPC_JUMP  = 6'b000101;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } hz_state_e;

   // Instruction reads rs as a source operand.
   function automatic logic uses_rs_src(input logic [OPC_W-1:0] opcode);
      case (opcode)
         OPC_RTYPE, OPC_LW, OPC_SW, OPC_BEQ, OPC_ADDI: uses_rs_src = 1'b1;
         default:                                      uses_rs_src = 1'b0;
      endcase
   endfunction

   // Instruction reads rt as a source operand (ADDI/LW write rt instead).
   function automatic logic uses_rt_src(input logic [OPC_W-1:0] opcode);
      case (opcode)
         OPC_RTYPE, OPC_SW, OPC_BEQ: uses_rt_src = 1'b1;
         default:                    uses_rt_src = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Decode/execute hazard inputs and pipeline-register controls of the hazard sequencer.
interface hazard_sequencer_if;
   import hazard_pkg::*;

   logic [OPC_W-1:0]  id_opcode;
   logic [REG_W-1:0]  id_rs;
   logic [REG_W-1:0]  id_rt;
   logic              ex_mem_read;
   logic [REG_W-1:0]  ex_rt;
   logic              branch_out_ex_dm;
   logic              pc_write;
   logic              ifid_write;
   logic              ifid_flush;
   logic              idex_bubble;
   logic [1:0]        hz_state;
   logic [PERF_W-1:0] stall_count;
   logic [PERF_W-1:0] flush_count;

   modport master (
      output id_opcode, id_rs, id_rt, ex_mem_read, ex_rt, branch_out_ex_dm,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, hz_state,
             stall_count, flush_count
   );

   modport slave (
      input  id_opcode, id_rs, id_rt, ex_mem_read, ex_rt, branch_out_ex_dm,
      output pc_write, ifid_write, ifid_flush, idex_bubble, hz_state,
             stall_count, flush_count
   );

endinterface

// File: rtl/hazard_perf_counter.sv
// 32-bit wrapping event counter with synchronous active-high reset.
module hazard_perf_counter
   import hazard_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   output logic [PERF_W-1:0] count
);

   logic [PERF_W-1:0] count_q;
   logic [PERF_W-1:0] count_d;

   assign count_d = inc ? count_q + PERF_W'(1) : count_q;

   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Load-use / branch / jump hazard controller driving PC, IF/ID and ID/EX controls (Mealy).
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_sequencer
   import hazard_pkg::*;
#(
   parameter int unsigned LOAD_STALL_CYCLES = 1,
   parameter int unsigned FLUSH_CYCLES      = 1
) (
   input  logic             clk,
   input  logic             reset,
   hazard_sequencer_if.slave hz
);

   localparam int unsigned MAX_CYC = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES
                                                                         : FLUSH_CYCLES;
   localparam int unsigned DCNT_W  = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int unsigned STALL_RELOAD_I = (LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0;
   localparam int unsigned FLUSH_RELOAD_I = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;
   localparam logic [DCNT_W-1:0] STALL_RELOAD = DCNT_W'(STALL_RELOAD_I);
   localparam logic [DCNT_W-1:0] FLUSH_RELOAD = DCNT_W'(FLUSH_RELOAD_I);

   hz_state_e         state_q, state_d;
   logic [DCNT_W-1:0] cnt_q, cnt_d;

   logic lu_c;
   logic jump_c;
   logic pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c;

   assign lu_c = hz.ex_mem_read && (hz.ex_rt != '0) &&
                 ((uses_rs_src(hz.id_opcode) && (hz.ex_rt == hz.id_rs)) ||
                  (uses_rt_src(hz.id_opcode) && (hz.ex_rt == hz.id_rt)));
   assign jump_c = (hz.id_opcode == OPC_JUMP);

   // Next state and Mealy controls; a taken branch overrides every state.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pc_write_c    = 1'b1;
      ifid_write_c  = 1'b1;
      ifid_flush_c  = 1'b0;
      idex_bubble_c = 1'b0;

      if (hz.branch_out_ex_dm) begin
         ifid_flush_c  = 1'b1;
         idex_bubble_c = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
         end else begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               if (lu_c) begin
                  pc_write_c    = 1'b0;
                  ifid_write_c  = 1'b0;
                  idex_bubble_c = 1'b1;
                  if (LOAD_STALL_CYCLES > 1) begin
                     state_d = ST_STALL;
                     cnt_d   = STALL_RELOAD;
                  end
               end else if (jump_c) begin
                  ifid_flush_c = 1'b1;
               end
            end
            ST_STALL: begin
               pc_write_c    = 1'b0;
               ifid_write_c  = 1'b0;
               idex_bubble_c = 1'b1;
               if (cnt_q == '0) state_d = ST_RUN;
               else             cnt_d   = cnt_q - DCNT_W'(1);
            end
            ST_FLUSH: begin
               ifid_flush_c  = 1'b1;
               idex_bubble_c = 1'b1;
               if (cnt_q == '0) state_d = ST_RUN;
               else             cnt_d   = cnt_q - DCNT_W'(1);
            end
            default: begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         endcase
      end

      if (reset) begin
         pc_write_c    = 1'b0;
         ifid_write_c  = 1'b0;
         ifid_flush_c  = 1'b1;
         idex_bubble_c = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign hz.pc_write    = pc_write_c;
   assign hz.ifid_write  = ifid_write_c;
   assign hz.ifid_flush  = ifid_flush_c;
   assign hz.idex_bubble = idex_bubble_c;
   assign hz.hz_state    = reset ? ST_RUN : state_q;

`ifdef HAZARD_PERF_CNT_EN
   logic stall_inc_c;
   logic flush_inc_c;

   // A jump is only accepted in RUN when neither a branch nor a load-use outranks it.
   assign stall_inc_c = !reset && !pc_write_c;
   assign flush_inc_c = !reset &&
                        (hz.branch_out_ex_dm || ((state_q == ST_RUN) && !lu_c && jump_c));

   hazard_perf_counter u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc_c),
      .count (hz.stall_count)
   );

   hazard_perf_counter u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_inc_c),
      .count (hz.flush_count)
   );
`else
   assign hz.stall_count = '0;
   assign hz.flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench: default-parameter instance (a) and LOAD_STALL_CYCLES=3/FLUSH_CYCLES=2 instance (b).
module tb_hazard_sequencer;
   import hazard_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // {pc_write, ifid_write, ifid_flush, idex_bubble, hz_state}
   localparam logic [5:0] C_RST    = 6'b001100;
   localparam logic [5:0] C_RUN    = 6'b110000;
   localparam logic [5:0] C_STALL0 = 6'b000100;
   localparam logic [5:0] C_STALL1 = 6'b000101;
   localparam logic [5:0] C_FLUSH0 = 6'b111100;
   localparam logic [5:0] C_FLUSH2 = 6'b111110;
   localparam logic [5:0] C_JUMP   = 6'b111000;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   hazard_sequencer_if if_a ();
   hazard_sequencer_if if_b ();

   hazard_sequencer #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1)) dut_a (
      .clk   (clk),
      .reset (reset),
      .hz    (if_a.slave)
   );

   hazard_sequencer #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2)) dut_b (
      .clk   (clk),
      .reset (reset),
      .hz    (if_b.slave)
   );

   wire [5:0] ctl_a = {if_a.pc_write, if_a.ifid_write, if_a.ifid_flush, if_a.idex_bubble, if_a.hz_state};
   wire [5:0] ctl_b = {if_b.pc_write, if_b.ifid_write, if_b.ifid_flush, if_b.idex_bubble, if_b.hz_state};

   task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic mr, input logic [4:0] ert, input logic br);
      if_a.id_opcode = op;  if_a.id_rs = rs; if_a.id_rt = rt;
      if_a.ex_mem_read = mr; if_a.ex_rt = ert; if_a.branch_out_ex_dm = br;
      if_b.id_opcode = op;  if_b.id_rs = rs; if_b.id_rt = rt;
      if_b.ex_mem_read = mr; if_b.ex_rt = ert; if_b.branch_out_ex_dm = br;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(OPC_RTYPE, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(OPC_RTYPE, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1);
      @(negedge clk);
      checks++;
      if (ctl_a !== C_RST) begin errors++; $display("FAIL reset_ctl_a got %b exp %b", ctl_a, C_RST); end
      checks++;
      if (ctl_b !== C_RST) begin errors++; $display("FAIL reset_ctl_b got %b exp %b", ctl_b, C_RST); end
      next_cycle();
      @(negedge clk);
      checks++;
      if (if_a.stall_count !== 32'd0 || if_a.flush_count !== 32'd0) begin
         errors++; $display("FAIL reset_counters got %h/%h exp 0/0", if_a.stall_count, if_a.flush_count);
      end
      checks++;
      if (ctl_a !== C_RST) begin errors++; $display("FAIL reset_hold_ctl_a got %b exp %b", ctl_a, C_RST); end
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_run();
      drive(OPC_RTYPE, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (ctl_a !== C_RUN) begin errors++; $display("FAIL run_ctl_a got %b exp %b", ctl_a, C_RUN); end
      checks++;
      if (if_a.stall_count !== 32'd0 || if_a.flush_count !== 32'd0) begin
         errors++; $display("FAIL run_counters got %h/%h exp 0/0", if_a.stall_count, if_a.flush_count);
      end
      next_cycle();
   endtask

   task automatic test_load_use();
      logic [31:0] exp_cnt;
      exp_cnt = PERF ? 32'd1 : 32'd0;
      do_reset();
      drive(OPC_RTYPE, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0);
      @(negedge clk);
      checks++;
      if (ctl_a !== C_STALL0) begin errors++; $display("FAIL lu_rtype_rs got %b exp %b", ctl_a, C_STALL0); end
      next_cycle();
      drive(OPC_RTYPE, 5'd1, 5'd2, 1'b0, 5'd5, 1'b0);
      @(negedge clk);
      checks++;
      if (ctl_a !== C_RUN) begin errors++; $display("FAIL lu_release got %b exp %b", ctl_a, C_RUN); end
      checks++;
      if (if_a.stall_count !== exp_cnt) begin
         errors++; $display("FAIL lu_stall_count got %0d exp %0d", if_a.stall_count, exp_cnt);
      end
      next_cycle();
      drive(OPC_ADDI, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0);
      @(negedge clk);
      checks++;
      if (ctl_a !== C_RUN) begin errors++; $display("FAIL lu_addi_rt got %b exp %b", ctl_a, C_RUN); end
      next_cycle();
      drive(OPC_RTYPE, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (ctl_a !== C_RUN) begin errors++; $display("FAIL lu_r0 got %b exp %b", ctl_a, C_RUN); end
      next_cycle();
      drive(OPC_JUMP, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0);
      @(negedge clk);
      checks++;
      if (ctl_a !== C_JUMP) begin errors++; $display("FAIL lu_jump_never got %b exp %b", ctl_a, C_JUMP); end
      next_cycle();
      drive(OPC_RTYPE, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (if_a.stall_count !== exp_cnt) begin
         errors++; $display("FAIL lu_no_extra_stall got %0d exp %0d", if_a.stall_count, exp_cnt);
      end
      next_cycle();
   endtask

   task automatic test_long_stall();
      logic [5:0] exp_seq [4];
      logic [31:0] exp_cnt;
      exp_seq[0] = C_STALL0; exp_seq[1] = C_STALL1; exp_seq[2] = C_STALL1; exp_seq[3] = C_RUN;
      exp_cnt = PERF ? 32'd3 : 32'd0;
      do_reset();
      drive(OPC_SW, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (ctl_b !== exp_seq[i]) begin
            errors++; $display("FAIL long_stall_c%0d got %b exp %b", i, ctl_b, exp_seq[i]);
         end
         next_cycle();
         drive(OPC_RTYPE, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      end
      @(negedge clk);
      checks++;
      if (if_b.stall_count !== exp_cnt) begin
         errors++; $display("FAIL long_stall_count got %0d exp %0d", if_b.stall_count, exp_cnt);
      end
      next_cycle();
   endtask

   task automatic test_branch_priority();
      logic [31:0] exp_f;
      exp_f = PERF ? 32'd1 : 32'd0;
      do_reset();
      drive(OPC_RTYPE, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1);
      @(negedge clk);
      checks++;
      if (ctl_b !== C_FLUSH0) begin errors++; $display("FAIL br_wins_b got %b exp %b", ctl_b, C_FLUSH0); end
      checks++;
      if (ctl_a !== C_FLUSH0) begin errors++; $display("FAIL br_wins_a got %b exp %b", ctl_a, C_FLUSH0); end
      next_cycle();
      drive(OPC_RTYPE, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (ctl_b !== C_FLUSH2) begin errors++; $display("FAIL br_flush2_b got %b exp %b", ctl_b, C_FLUSH2); end
      checks++;
      if (ctl_a !== C_RUN) begin errors++; $display("FAIL br_flush1_a got %b exp %b", ctl_a, C_RUN); end
      next_cycle();
      @(negedge clk);
      checks++;
      if (ctl_b !== C_RUN) begin errors++; $display("FAIL br_done_b got %b exp %b", ctl_b, C_RUN); end
      checks++;
      if (if_b.flush_count !== exp_f || if_b.stall_count !== 32'd0) begin
         errors++; $display("FAIL br_counts got f=%0d s=%0d exp f=%0d s=0", if_b.flush_count, if_b.stall_count, exp_f);
      end
      next_cycle();
   endtask

   task automatic test_jump();
      logic [31:0] exp_f;
      exp_f = PERF ? 32'd1 : 32'd0;
      do_reset();
      drive(OPC_JUMP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (ctl_a !== C_JUMP) begin errors++; $display("FAIL jump_ctl got %b exp %b", ctl_a, C_JUMP); end
      next_cycle();
      drive(OPC_RTYPE, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (ctl_a !== C_RUN || if_a.flush_count !== exp_f) begin
         errors++; $display("FAIL jump_count got ctl=%b f=%0d exp ctl=%b f=%0d", ctl_a, if_a.flush_count, C_RUN, exp_f);
      end
      next_cycle();
      // jump seen while instance b is in FLUSH
      do_reset();
      drive(OPC_RTYPE, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1);
      next_cycle();
      drive(OPC_JUMP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (ctl_b !== C_FLUSH2) begin errors++; $display("FAIL jump_in_flush got %b exp %b", ctl_b, C_FLUSH2); end
      next_cycle();
      drive(OPC_RTYPE, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (ctl_b !== C_RUN || if_b.flush_count !== exp_f) begin
         errors++; $display("FAIL jump_in_flush_count got ctl=%b f=%0d exp ctl=%b f=%0d", ctl_b, if_b.flush_count, C_RUN, exp_f);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      drive(OPC_SW, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0);
      @(negedge clk);
      checks++;
      if (ctl_b !== C_STALL0) begin errors++; $display("FAIL rms_start got %b exp %b", ctl_b, C_STALL0); end
      next_cycle();
      drive(OPC_RTYPE, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (ctl_b !== C_RST) begin errors++; $display("FAIL rms_reset got %b exp %b", ctl_b, C_RST); end
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (ctl_b !== C_RUN) begin errors++; $display("FAIL rms_after got %b exp %b", ctl_b, C_RUN); end
      checks++;
      if (if_b.stall_count !== 32'd0 || if_b.flush_count !== 32'd0) begin
         errors++; $display("FAIL rms_counters got %0d/%0d exp 0/0", if_b.stall_count, if_b.flush_count);
      end
      next_cycle();
   endtask

   task automatic test_wrap();
      do_reset();
`ifdef HAZARD_PERF_CNT_EN
      dut_a.u_stall_cnt.count_q = 32'hFFFF_FFFF;
`endif
      drive(OPC_RTYPE, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0);
      @(negedge clk);
      checks++;
      if (ctl_a !== C_STALL0) begin errors++; $display("FAIL wrap_stall got %b exp %b", ctl_a, C_STALL0); end
      next_cycle();
      drive(OPC_RTYPE, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (if_a.stall_count !== 32'd0) begin
         errors++; $display("FAIL wrap_count got %h exp 00000000", if_a.stall_count);
      end
      next_cycle();
   endtask

   initial begin
      reset = 1'b1;
      drive(OPC_RTYPE, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      test_reset();
      test_run();
      test_load_use();
      test_long_stall();
      test_branch_priority();
      test_jump();
      test_reset_mid_stall();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
